// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side bundle shared by the fetch/data arbiter.
// The slave view belongs to the arbiter; the master view to requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              IF_REQ;
    logic [ADDR_W-1:0] IF_ADDR;
    logic              IF_GNT;
    logic              IF_RVALID;
    logic [DATA_W-1:0] IF_RDATA;

    logic              DM_REQ;
    logic              DM_WE;
    logic [ADDR_W-1:0] DM_ADDR;
    logic [DATA_W-1:0] DM_WDATA;
    logic [1:0]        DM_SIZE;
    logic              DM_GNT;
    logic              DM_RVALID;
    logic [DATA_W-1:0] DM_RDATA;

    logic              MEM_EN;
    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [DATA_W-1:0] MEM_WDATA;
    logic [1:0]        MEM_SIZE;
    logic [DATA_W-1:0] MEM_RDATA;

    logic              BUSY;

    modport slave (
        input  IF_REQ, IF_ADDR,
        input  DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_SIZE,
        input  MEM_RDATA,
        output IF_GNT, IF_RVALID, IF_RDATA,
        output DM_GNT, DM_RVALID, DM_RDATA,
        output MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE,
        output BUSY
    );

    modport master (
        output IF_REQ, IF_ADDR,
        output DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_SIZE,
        output MEM_RDATA,
        input  IF_GNT, IF_RVALID, IF_RDATA,
        input  DM_GNT, DM_RVALID, DM_RDATA,
        input  MEM_EN, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE,
        input  BUSY
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one fixed-latency memory port between fetch and data.
// Data wins by default; a saturating starvation count hands the port to a waiting fetch.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_SAT  = STV_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [STV_W-1:0]  starve_q, starve_d;
    logic              owner_dm_q, owner_dm_d;
    logic              gnt_if_c, gnt_dm_c, capture_c;

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [1:0]        mem_size_c;
    logic              mem_we_c;

    logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
    logic              if_rvalid_q, dm_rvalid_q;

    // RESP arbitrates exactly like IDLE so a new grant can overlap the response pulse
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        owner_dm_d = owner_dm_q;
        gnt_if_c   = 1'b0;
        gnt_dm_c   = 1'b0;
        capture_c  = 1'b0;

        case (state_q)
            WAIT: begin
                if (cnt_q == '0) begin
                    capture_c = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                if (RST_N && bus.DM_REQ && ((starve_q < STV_SAT) || !bus.IF_REQ)) begin
                    gnt_dm_c = 1'b1;
                end else if (RST_N && bus.IF_REQ) begin
                    gnt_if_c = 1'b1;
                end
                if (gnt_dm_c || gnt_if_c) begin
                    state_d    = WAIT;
                    cnt_d      = CNT_LOAD;
                    owner_dm_d = gnt_dm_c;
                end
            end
        endcase

        if (!bus.IF_REQ || gnt_if_c) begin
            starve_d = '0;
        end else if (gnt_dm_c && (starve_q != STV_SAT)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Memory bus follows the granted requester, otherwise replays the last issue
    always_comb begin
        mem_addr_c  = addr_q;
        mem_wdata_c = wdata_q;
        mem_size_c  = size_q;
        mem_we_c    = we_q;
        if (gnt_dm_c) begin
            mem_addr_c  = bus.DM_ADDR;
            mem_wdata_c = bus.DM_WDATA;
            mem_size_c  = bus.DM_SIZE;
            mem_we_c    = bus.DM_WE;
        end else if (gnt_if_c) begin
            mem_addr_c  = bus.IF_ADDR;
            mem_size_c  = 2'd2;
            mem_we_c    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            starve_q   <= '0;
            owner_dm_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            owner_dm_q <= owner_dm_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
        end else if (gnt_dm_c || gnt_if_c) begin
            addr_q  <= mem_addr_c;
            wdata_q <= mem_wdata_c;
            size_q  <= mem_size_c;
            we_q    <= mem_we_c;
        end
    end

    // Response capture: only the owner's data register moves
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
        end else begin
            if_rvalid_q <= capture_c && !owner_dm_q;
            dm_rvalid_q <= capture_c && owner_dm_q;
            if (capture_c && owner_dm_q)  dm_rdata_q <= bus.MEM_RDATA;
            if (capture_c && !owner_dm_q) if_rdata_q <= bus.MEM_RDATA;
        end
    end

    assign bus.IF_GNT    = gnt_if_c;
    assign bus.DM_GNT    = gnt_dm_c;
    assign bus.MEM_EN    = gnt_if_c | gnt_dm_c;
    assign bus.MEM_ADDR  = mem_addr_c;
    assign bus.MEM_WDATA = mem_wdata_c;
    assign bus.MEM_SIZE  = mem_size_c;
    assign bus.MEM_WE    = mem_we_c;
    assign bus.IF_RDATA  = if_rdata_q;
    assign bus.DM_RDATA  = dm_rdata_q;
    assign bus.IF_RVALID = if_rvalid_q;
    assign bus.DM_RVALID = dm_rvalid_q;
    assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LAT=2 and one at MEM_LAT=1,
// each backed by a fixed-latency memory model.
module tb_mem_port_arbiter;
    logic CLK;
    logic RST_N;
    int   n_vec = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) A ();
    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) B ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut_a (
        .CLK(CLK), .RST_N(RST_N), .bus(A)
    );
    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_b (
        .CLK(CLK), .RST_N(RST_N), .bus(B)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] rd(input logic [15:0] a);
        if (a == 16'h0010) return 32'h00500093;
        return {a ^ 16'h5A5A, a};
    endfunction

    // Memory models: word for the issued address appears MEM_LAT cycles after MEM_EN
    logic [31:0] pa0, pa1, pb0;
    always @(posedge CLK) begin
        if (A.MEM_EN) pa0 <= rd(A.MEM_ADDR);
        pa1 <= pa0;
        if (B.MEM_EN) pb0 <= rd(B.MEM_ADDR);
    end
    assign A.MEM_RDATA = pa1;
    assign B.MEM_RDATA = pb0;

    // {IF_GNT, DM_GNT, MEM_EN, BUSY, IF_RVALID, DM_RVALID}
    logic [5:0] ctl_a, ctl_b;
    assign ctl_a = {A.IF_GNT, A.DM_GNT, A.MEM_EN, A.BUSY, A.IF_RVALID, A.DM_RVALID};
    assign ctl_b = {B.IF_GNT, B.DM_GNT, B.MEM_EN, B.BUSY, B.IF_RVALID, B.DM_RVALID};

    task automatic idle_inputs();
        A.IF_REQ = 1'b0; A.IF_ADDR = '0; A.DM_REQ = 1'b0; A.DM_WE = 1'b0;
        A.DM_ADDR = '0; A.DM_WDATA = '0; A.DM_SIZE = 2'd0;
        B.IF_REQ = 1'b0; B.IF_ADDR = '0; B.DM_REQ = 1'b0; B.DM_WE = 1'b0;
        B.DM_ADDR = '0; B.DM_WDATA = '0; B.DM_SIZE = 2'd0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle_inputs();
        A.IF_REQ = 1'b1; A.DM_REQ = 1'b1; A.DM_ADDR = 16'h1234; B.IF_REQ = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        n_vec++;
        if (ctl_a !== 6'b000000) begin n_err++; $display("FAIL reset_ctl_a: got %b expected %b", ctl_a, 6'b000000); end
        n_vec++;
        if (ctl_b !== 6'b000000) begin n_err++; $display("FAIL reset_ctl_b: got %b expected %b", ctl_b, 6'b000000); end
        n_vec++;
        if ({A.IF_RDATA, A.DM_RDATA} !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", {A.IF_RDATA, A.DM_RDATA}); end
        n_vec++;
        if (A.MEM_ADDR !== 16'h0000) begin n_err++; $display("FAIL reset_mem_addr: got %h expected 0000", A.MEM_ADDR); end
        idle_inputs();
        next_cycle();
        RST_N = 1'b1;
    endtask

    task automatic test_fetch_only();
        logic [5:0] exp [8] = '{6'b101000, 6'b000100, 6'b000100, 6'b101110,
                                6'b000100, 6'b000100, 6'b000110, 6'b000000};
        for (int c = 0; c < 8; c++) begin
            A.IF_REQ  = (c < 4);
            A.IF_ADDR = (c == 0) ? 16'h0010 : 16'h0014;
            @(negedge CLK);
            n_vec++;
            if (ctl_a !== exp[c]) begin n_err++; $display("FAIL fetch_ctl c%0d: got %b expected %b", c, ctl_a, exp[c]); end
            if (c == 0) begin
                n_vec++;
                if (A.MEM_ADDR !== 16'h0010) begin n_err++; $display("FAIL fetch_addr0: got %h expected 0010", A.MEM_ADDR); end
            end
            if (c == 3) begin
                n_vec++;
                if (A.IF_RDATA !== 32'h00500093) begin n_err++; $display("FAIL fetch_rdata0: got %h expected 00500093", A.IF_RDATA); end
                n_vec++;
                if (A.MEM_ADDR !== 16'h0014) begin n_err++; $display("FAIL fetch_addr1: got %h expected 0014", A.MEM_ADDR); end
            end
            if (c == 6) begin
                n_vec++;
                if (A.IF_RDATA !== rd(16'h0014)) begin n_err++; $display("FAIL fetch_rdata1: got %h expected %h", A.IF_RDATA, rd(16'h0014)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_simultaneous();
        logic [5:0] exp [8] = '{6'b011000, 6'b000100, 6'b000100, 6'b101101,
                                6'b000100, 6'b000100, 6'b000110, 6'b000000};
        A.IF_ADDR = 16'h0020; A.DM_ADDR = 16'h0200; A.DM_WE = 1'b0; A.DM_SIZE = 2'd2;
        for (int c = 0; c < 8; c++) begin
            A.IF_REQ = (c < 4);
            A.DM_REQ = (c == 0);
            @(negedge CLK);
            n_vec++;
            if (ctl_a !== exp[c]) begin n_err++; $display("FAIL simul_ctl c%0d: got %b expected %b", c, ctl_a, exp[c]); end
            if (c == 0) begin
                n_vec++;
                if (A.MEM_ADDR !== 16'h0200) begin n_err++; $display("FAIL simul_dm_addr: got %h expected 0200", A.MEM_ADDR); end
            end
            if (c == 3) begin
                n_vec++;
                if (A.DM_RDATA !== rd(16'h0200)) begin n_err++; $display("FAIL simul_dm_rdata: got %h expected %h", A.DM_RDATA, rd(16'h0200)); end
                n_vec++;
                if (A.MEM_ADDR !== 16'h0020) begin n_err++; $display("FAIL simul_if_addr: got %h expected 0020", A.MEM_ADDR); end
            end
            if (c == 6) begin
                n_vec++;
                if (A.IF_RDATA !== rd(16'h0020)) begin n_err++; $display("FAIL simul_if_rdata: got %h expected %h", A.IF_RDATA, rd(16'h0020)); end
            end
            next_cycle();
        end
    endtask

    task automatic test_store();
        logic [5:0] exp [5] = '{6'b011000, 6'b000100, 6'b000100, 6'b000101, 6'b000000};
        A.IF_REQ = 1'b0; A.DM_WE = 1'b1; A.DM_ADDR = 16'h0100;
        A.DM_WDATA = 32'hDEADBEEF; A.DM_SIZE = 2'd2;
        for (int c = 0; c < 5; c++) begin
            A.DM_REQ = (c == 0);
            @(negedge CLK);
            n_vec++;
            if (ctl_a !== exp[c]) begin n_err++; $display("FAIL store_ctl c%0d: got %b expected %b", c, ctl_a, exp[c]); end
            if (c == 0) begin
                n_vec++;
                if ({A.MEM_WE, A.MEM_SIZE, A.MEM_ADDR, A.MEM_WDATA} !== {1'b1, 2'd2, 16'h0100, 32'hDEADBEEF}) begin
                    n_err++; $display("FAIL store_bus: got we=%b size=%0d addr=%h wdata=%h expected we=1 size=2 addr=0100 wdata=deadbeef",
                                      A.MEM_WE, A.MEM_SIZE, A.MEM_ADDR, A.MEM_WDATA);
                end
            end
            if (c == 3) begin
                n_vec++;
                if (A.IF_RDATA !== rd(16'h0020)) begin n_err++; $display("FAIL store_if_rdata_held: got %h expected %h", A.IF_RDATA, rd(16'h0020)); end
            end
            if (c == 4) begin
                n_vec++;
                if ({A.MEM_WE, A.MEM_ADDR} !== {1'b1, 16'h0100}) begin n_err++; $display("FAIL store_bus_hold: got we=%b addr=%h expected we=1 addr=0100", A.MEM_WE, A.MEM_ADDR); end
            end
            next_cycle();
        end
        A.DM_WE = 1'b0;
    endtask

    task automatic test_starvation();
        logic [1:0] exp;
        A.DM_REQ = 1'b1; A.DM_WE = 1'b0; A.DM_ADDR = 16'h0300; A.DM_SIZE = 2'd2;
        A.IF_REQ = 1'b1; A.IF_ADDR = 16'h0040;
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (c % 3 != 0)              exp = 2'b00;
            else if ((c / 3) % 5 == 4)   exp = 2'b10;
            else                         exp = 2'b01;
            n_vec++;
            if (ctl_a[5:4] !== exp) begin n_err++; $display("FAIL starve_gnt c%0d: got if/dm=%b expected %b", c, ctl_a[5:4], exp); end
            next_cycle();
        end
        idle_inputs();
        repeat (2) next_cycle();
    endtask

    task automatic test_reset_mid_wait();
        logic [5:0] exp [5] = '{6'b011000, 6'b000100, 6'b000100, 6'b000101, 6'b000000};
        A.IF_REQ = 1'b1; A.IF_ADDR = 16'h0050;
        @(negedge CLK);
        n_vec++;
        if (ctl_a !== 6'b101000) begin n_err++; $display("FAIL rstw_grant: got %b expected %b", ctl_a, 6'b101000); end
        next_cycle();
        A.IF_REQ = 1'b0; A.DM_REQ = 1'b1; A.DM_ADDR = 16'h0400;
        RST_N = 1'b0;
        #1;
        n_vec++;
        if (ctl_a !== 6'b000000) begin n_err++; $display("FAIL rstw_ctl: got %b expected %b", ctl_a, 6'b000000); end
        n_vec++;
        if ({A.IF_RDATA, A.DM_RDATA} !== 64'h0) begin n_err++; $display("FAIL rstw_rdata: got %h expected 0", {A.IF_RDATA, A.DM_RDATA}); end
        repeat (2) next_cycle();
        RST_N = 1'b1;
        for (int c = 0; c < 5; c++) begin
            A.DM_REQ = (c == 0);
            @(negedge CLK);
            n_vec++;
            if (ctl_a !== exp[c]) begin n_err++; $display("FAIL rstw_post c%0d: got %b expected %b", c, ctl_a, exp[c]); end
            if (c == 0) begin
                n_vec++;
                if (A.MEM_ADDR !== 16'h0400) begin n_err++; $display("FAIL rstw_addr: got %h expected 0400", A.MEM_ADDR); end
            end
            if (c == 3) begin
                n_vec++;
                if ({A.IF_RDATA, A.DM_RDATA} !== {32'h0, rd(16'h0400)}) begin
                    n_err++; $display("FAIL rstw_rdata_post: got if=%h dm=%h expected if=0 dm=%h", A.IF_RDATA, A.DM_RDATA, rd(16'h0400));
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back_lat1();
        logic [5:0]  exp;
        logic [15:0] a_exp;
        for (int c = 0; c < 10; c++) begin
            B.IF_REQ  = (c < 8);
            B.IF_ADDR = 16'h0100 + 16'(4 * ((c + 1) / 2));
            if (c == 0)                   exp = 6'b101000;
            else if (c == 9)              exp = 6'b000000;
            else if (c == 8)              exp = 6'b000110;
            else if (c % 2 == 0)          exp = 6'b101110;
            else                          exp = 6'b000100;
            @(negedge CLK);
            n_vec++;
            if (ctl_b !== exp) begin n_err++; $display("FAIL lat1_ctl c%0d: got %b expected %b", c, ctl_b, exp); end
            if (c >= 2 && c <= 8 && c % 2 == 0) begin
                a_exp = 16'h0100 + 16'(4 * (c / 2 - 1));
                n_vec++;
                if (B.IF_RDATA !== rd(a_exp)) begin n_err++; $display("FAIL lat1_rdata c%0d: got %h expected %h", c, B.IF_RDATA, rd(a_exp)); end
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_starvation();
        test_reset_mid_wait();
        test_back_to_back_lat1();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the pipelined CPU. Only one access is outstanding at a time. Each requester sees a req/gnt/rvalid handshake, and the memory has a fixed read latency. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface
Parameters:
- ADDR_W, 16, address width (matches 16-bit PC)
- DATA_W, 32, data width
- MEM_LAT, 2, cycles from issue to MEM_RDATA valid; legal range ≥1
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits; legal range ≥1

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- IF_REQ  in  1  fetch request; held with IF_ADDR until IF_GNT
- IF_ADDR  in  ADDR_W  fetch address
- IF_GNT  out  1  fetch request accepted this cycle
- IF_RVALID  out  1  one-cycle pulse, IF_RDATA valid
- IF_RDATA  out  DATA_W  fetched word (registered)
- DM_REQ  in  1  data request; held with DM_* until DM_GNT
- DM_WE  in  1  1 = store, 0 = load
- DM_ADDR  in  ADDR_W  data address
- DM_WDATA  in  DATA_W  store data
- DM_SIZE  in  2  0 = byte, 1 = half, 2 = word; passed through unchanged
- DM_GNT  out  1  data request accepted this cycle
- DM_RVALID  out  1  one-cycle pulse: load data valid, or store done
- DM_RDATA  out  DATA_W  load data (registered)
- MEM_EN  out  1  issue strobe to memory
- MEM_WE, MEM_ADDR, MEM_WDATA, MEM_SIZE  out  1/ADDR_W/DATA_W/2  muxed from the granted requester
- MEM_RDATA  in  DATA_W  valid exactly MEM_LAT cycles after MEM_EN
- BUSY  out  1  access outstanding (state ≠ IDLE)

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - If DM_REQ=1 and the starvation count is below STARVE_MAX, or IF_REQ=0: grant data.
  - Else if IF_REQ=1: grant fetch.
  - The grant is combinational in the same cycle. GNT, MEM_EN and the MEM_* mux are asserted together.
  - Latch the owner (IF/DM) and the write flag. Load the latency counter with MEM_LAT−1. Go to WAIT.
- WAIT: decrement the counter each cycle. When the counter is 0, capture MEM_RDATA into the owner's RDATA register and go to RESP.
- RESP:
  - Owner's RVALID=1 for exactly this cycle.
  - State returns to IDLE combinationally for arbitration, so a new grant may be issued in this same cycle.
  - RESP behaves as IDLE plus the RVALID pulse.
- Stores also complete through WAIT/RESP. DM_RVALID is the write acknowledge. DM_RDATA is still loaded from MEM_RDATA (don't-care for stores).
- Starvation counter (width clog2(STARVE_MAX+1)):
  - Increments on each DM grant while IF_REQ=1.
  - Clears on any IF grant or whenever IF_REQ=0.
  - Saturates at STARVE_MAX. At STARVE_MAX a pending fetch wins over data.
- Non-owner RDATA holds its value. IF_RDATA only changes on IF responses, DM_RDATA only on DM responses.
- The MEM_* bus outside a grant cycle holds the last granted values. MEM_EN=0.

## Timing
- Issue at cycle t: GNT=1 and MEM_EN=1 in cycle t.
- MEM_RDATA is sampled at the end of cycle t+MEM_LAT.
- RVALID and RDATA are visible in cycle t+MEM_LAT+1.
- The earliest next grant is cycle t+MEM_LAT+1. Peak throughput is one access per MEM_LAT+1 cycles.
- GNT is never asserted in WAIT. At most one of IF_GNT/DM_GNT is high in any cycle.
- A request dropped before grant is legal: no access, no response.
- Reset values (asserted immediately on RST_N low, held until release):
  - state IDLE, counter 0, starvation count 0
  - IF_RDATA and DM_RDATA = 0
  - IF_RVALID and DM_RVALID = 0, BUSY = 0
  - IF_GNT, DM_GNT and MEM_EN forced to 0 while RST_N=0
- Reset mid-access: the in-flight response is discarded and no RVALID follows. The first grant is possible in the first cycle after RST_N rises.

## Test plan
- Fetch only, MEM_LAT=2: IF_REQ=1, IF_ADDR=0x0010, memory returns 0x00500093.
  - IF_GNT at cycle 0.
  - IF_RVALID and IF_RDATA=0x00500093 at cycle 3.
  - Next IF_GNT at cycle 3. BUSY=1 in cycles 1–2.
- Simultaneous requests: IF_REQ=DM_REQ=1 at cycle 0.
  - DM_GNT at cycle 0 with MEM_ADDR=DM_ADDR.
  - IF_GNT at cycle 3, IF_RVALID at cycle 6.
- Store: DM_WE=1, DM_ADDR=0x0100, DM_WDATA=0xDEADBEEF, DM_SIZE=2.
  - MEM_WE=1 and MEM_WDATA=0xDEADBEEF in the grant cycle.
  - DM_RVALID exactly MEM_LAT+1 cycles later.
  - IF_RDATA unchanged.
- Starvation, STARVE_MAX=4: DM_REQ and IF_REQ held high continuously.
  - Grant sequence is DM,DM,DM,DM,IF,DM,DM,DM,DM,IF…
  - No IF_GNT/DM_GNT overlap.
- Reset mid-WAIT: drop RST_N one cycle after the grant.
  - All outputs go to 0 immediately.
  - No RVALID after release.
  - A fresh request is granted in the first post-reset cycle.
- MEM_LAT=1 sweep: back-to-back fetches are granted every 2 cycles. RDATA matches the MEM_RDATA of the corresponding issue.
